// File: rtl/imem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : imem_port_arbiter_if
// Brief    : Bundle of the fetch port, the load/store port and the RAM port
//            that meet at the shared program+data memory arbiter.
//            slave  - the arbiter's view (serves requesters, drives the RAM)
//            master - the surrounding core/RAM view
// Revision : 1.0 - initial release
// ============================================================================

interface imem_port_arbiter_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);

  // Instruction-fetch requester
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;

  // Load/store requester
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;

  // Single-port synchronous-read RAM
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    input  d_req, d_we, d_addr, d_wdata,
    input  mem_rdata,
    output if_ack, if_rdata,
    output d_ack, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr,
    output d_req, d_we, d_addr, d_wdata,
    output mem_rdata,
    input  if_ack, if_rdata,
    input  d_ack, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

`default_nettype wire

// File: rtl/imem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : imem_port_arbiter
// Brief    : Shares one single-port, synchronous-read word RAM between the
//            instruction-fetch port and the load/store port. Data has fixed
//            priority over fetch, with a starvation guard that forces fetch to
//            win after STARVE_MAX consecutive lost arbitrations (0 disables).
//            Each access walks IDLE -> ACCESS -> RESP; peak throughput is one
//            access every two cycles.
// Revision : 1.0 - initial release
// ============================================================================

module imem_port_arbiter #(
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               rst,   // synchronous, active-low
  imem_port_arbiter_if.slave bus
);

  // Starvation counter only has to hold 0..STARVE_MAX.
  localparam int               CNT_W        = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] C_STARVE_MAX = CNT_W'(STARVE_MAX);
  localparam bit               C_GUARD_EN   = (STARVE_MAX > 0);

  // Owner encoding; fetch is the reset value.
  localparam logic C_OWN_IF = 1'b0;
  localparam logic C_OWN_D  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_owner;
  logic [CNT_W-1:0]  r_starve_cnt;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;

  logic              w_arb_window;
  logic              w_if_cand;
  logic              w_d_cand;
  logic              w_force_if;
  logic              w_grant_d;
  logic              w_grant_if;
  logic              w_grant_any;
  logic [CNT_W-1:0]  w_starve_nxt;
  logic              w_if_ack;
  logic              w_d_ack;

  // Pick a winner in IDLE/RESP; in RESP the port being acked is not eligible,
  // so a request still held during its ack cycle is never served twice.
  always_comb begin
    w_arb_window = (r_state == ST_IDLE) || (r_state == ST_RESP);
    w_if_cand    = w_arb_window && bus.if_req
                   && !((r_state == ST_RESP) && (r_owner == C_OWN_IF));
    w_d_cand     = w_arb_window && bus.d_req
                   && !((r_state == ST_RESP) && (r_owner == C_OWN_D));
    w_force_if   = C_GUARD_EN && (r_starve_cnt == C_STARVE_MAX);
    w_grant_d    = w_d_cand && !(w_if_cand && w_force_if);
    w_grant_if   = w_if_cand && !w_grant_d;
    w_grant_any  = w_grant_d || w_grant_if;

    // Count fetch losses, saturating; any other decision outcome clears it.
    if (w_if_cand && w_grant_d) begin
      w_starve_nxt = (r_starve_cnt == C_STARVE_MAX) ? r_starve_cnt
                                                    : r_starve_cnt + 1'b1;
    end else begin
      w_starve_nxt = '0;
    end
  end

  // Access sequencer: latch the winner's command onto the RAM port, hold one
  // ACCESS cycle with mem_en high, then acknowledge in RESP.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_owner      <= C_OWN_IF;
      r_starve_cnt <= '0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_RESP: begin
          r_starve_cnt <= w_starve_nxt;
          if (w_grant_any) begin
            r_state  <= ST_ACCESS;
            r_owner  <= w_grant_d ? C_OWN_D : C_OWN_IF;
            r_mem_en <= 1'b1;
            if (w_grant_d) begin
              r_mem_we    <= bus.d_we;
              r_mem_addr  <= bus.d_addr;
              r_mem_wdata <= bus.d_wdata;
            end else begin
              r_mem_we    <= 1'b0;
              r_mem_addr  <= bus.if_addr;
            end
          end else begin
            r_state  <= ST_IDLE;
            r_mem_en <= 1'b0;
          end
        end
        ST_ACCESS: begin
          r_state  <= ST_RESP;
          r_mem_en <= 1'b0;
        end
        default: begin
          r_state  <= ST_IDLE;
          r_mem_en <= 1'b0;
        end
      endcase
    end
  end

  // Acks are decoded from state; read data is only forwarded to the owner.
  assign w_if_ack      = (r_state == ST_RESP) && (r_owner == C_OWN_IF);
  assign w_d_ack       = (r_state == ST_RESP) && (r_owner == C_OWN_D);

  assign bus.if_ack    = w_if_ack;
  assign bus.d_ack     = w_d_ack;
  assign bus.if_rdata  = w_if_ack ? bus.mem_rdata : '0;
  assign bus.d_rdata   = w_d_ack  ? bus.mem_rdata : '0;

  assign bus.mem_en    = r_mem_en;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;

endmodule

`default_nettype wire
